// File: rtl/video_pkg.sv
// ----------------------------------------------------------------------------
// video_pkg
// Shared definitions for the video output path. The FIFO-to-video stage and
// the upstream RAM reader both use these frame geometry defaults.
//   state_e         : IDLE / PRIME / RUN sequencing of video_out_gen
//   P_WIDTH/P_HEIGHT: default active pixels per line / active lines per frame
//   H_BLANK/V_BLANK : default blanking cycles per line / blanking lines
//   cnt_width()     : counter width needed to hold 0..total-1
// ----------------------------------------------------------------------------
package video_pkg;

    localparam int unsigned P_WIDTH  = 640;
    localparam int unsigned P_HEIGHT = 480;
    localparam int unsigned H_BLANK  = 160;
    localparam int unsigned V_BLANK  = 45;

    localparam int unsigned PIX_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PRIME = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    // Width of a counter spanning 0..total-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned total);
        return (total > 1) ? 32'($clog2(total)) : 32'd1;
    endfunction

endpackage : video_pkg

// File: rtl/video_timing_cnt.sv
// ----------------------------------------------------------------------------
// video_timing_cnt
// Horizontal / vertical raster counters for video_out_gen.
//   clk         : clock
//   rst_i       : synchronous active-high reset, clears both counters
//   clear_i     : hold both counters at zero (block not streaming)
//   advance_i   : step the raster by one pixel clock
//   h_cnt_o     : 0 .. P_WIDTH+H_BLANK-1
//   v_cnt_o     : 0 .. P_HEIGHT+V_BLANK-1, steps on each h_cnt wrap
//   active_o    : counters lie inside the active picture
//   frame_end_o : both counters at their terminal values
// ----------------------------------------------------------------------------
module video_timing_cnt
    import video_pkg::cnt_width;
#(
    parameter int unsigned P_WIDTH  = 640,
    parameter int unsigned P_HEIGHT = 480,
    parameter int unsigned H_BLANK  = 160,
    parameter int unsigned V_BLANK  = 45,
    parameter int unsigned H_TOTAL  = P_WIDTH + H_BLANK,
    parameter int unsigned V_TOTAL  = P_HEIGHT + V_BLANK,
    parameter int unsigned HW       = cnt_width(H_TOTAL),
    parameter int unsigned VW       = cnt_width(V_TOTAL)
) (
    input  logic          clk,
    input  logic          rst_i,
    input  logic          clear_i,
    input  logic          advance_i,
    output logic [HW-1:0] h_cnt_o,
    output logic [VW-1:0] v_cnt_o,
    output logic          active_o,
    output logic          frame_end_o
);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic          h_term;
    logic          v_term;

    // Terminal compares are done at 32 bits so a total that is an exact
    // power of two cannot truncate into a false match.
    assign h_term = (32'(h_cnt_q) == (H_TOTAL - 1));
    assign v_term = (32'(v_cnt_q) == (V_TOTAL - 1));

    // Next raster position: explicit wrap to zero keeps values inside range
    // even when the total is not a power of two.
    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (clear_i) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (advance_i) begin
            if (h_term) begin
                h_cnt_d = '0;
                v_cnt_d = v_term ? '0 : v_cnt_q + VW'(1);
            end else begin
                h_cnt_d = h_cnt_q + HW'(1);
            end
        end
    end

    // Counter state.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_cnt_o     = h_cnt_q;
    assign v_cnt_o     = v_cnt_q;
    assign active_o    = (32'(h_cnt_q) < P_WIDTH) && (32'(v_cnt_q) < P_HEIGHT);
    assign frame_end_o = h_term && v_term;

endmodule : video_timing_cnt

// File: rtl/video_out_gen.sv
// ----------------------------------------------------------------------------
// video_out_gen
// Drains a pixel FIFO into a raster video stream with line/frame valids.
//   clk         : clock
//   RST         : synchronous active-high reset
//   en          : stream enable (level); a running frame always completes
//   empty       : pixel FIFO empty flag
//   pixel_in    : FIFO read data, valid the cycle after r_e
//   r_e         : FIFO read enable (only on active pixels with data present)
//   pixel_out   : output pixel, 0x00 when no read was made
//   line_valid  : high on active pixels
//   frame_valid : high from first active pixel to last active pixel of frame
//   underflow   : sticky, set when an active pixel found the FIFO empty
// ----------------------------------------------------------------------------
module video_out_gen
    import video_pkg::state_e, video_pkg::ST_IDLE, video_pkg::ST_PRIME,
           video_pkg::ST_RUN, video_pkg::cnt_width, video_pkg::PIX_W;
#(
    parameter int unsigned P_WIDTH  = video_pkg::P_WIDTH,
    parameter int unsigned P_HEIGHT = video_pkg::P_HEIGHT,
    parameter int unsigned H_BLANK  = video_pkg::H_BLANK,
    parameter int unsigned V_BLANK  = video_pkg::V_BLANK
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             en,
    input  logic             empty,
    input  logic [PIX_W-1:0] pixel_in,
    output logic             r_e,
    output logic [PIX_W-1:0] pixel_out,
    output logic             line_valid,
    output logic             frame_valid,
    output logic             underflow
);

    localparam int unsigned H_TOTAL = P_WIDTH + H_BLANK;
    localparam int unsigned V_TOTAL = P_HEIGHT + V_BLANK;
    localparam int unsigned HW      = cnt_width(H_TOTAL);
    localparam int unsigned VW      = cnt_width(V_TOTAL);

    state_e        state_q;
    logic          rd_q;
    logic          line_valid_q;
    logic          frame_valid_q;
    logic          underflow_q;

    logic [HW-1:0] h_cnt;
    logic [VW-1:0] v_cnt;
    logic          cnt_active;
    logic          frame_end;
    logic          run;
    logic          act;
    logic          frame_win;

    assign run = (state_q == ST_RUN);

    // Counters only move in RUN; IDLE and PRIME hold them at zero.
    video_timing_cnt #(
        .P_WIDTH  (P_WIDTH),
        .P_HEIGHT (P_HEIGHT),
        .H_BLANK  (H_BLANK),
        .V_BLANK  (V_BLANK),
        .H_TOTAL  (H_TOTAL),
        .V_TOTAL  (V_TOTAL),
        .HW       (HW),
        .VW       (VW)
    ) u_timing (
        .clk         (clk),
        .rst_i       (RST),
        .clear_i     (!run),
        .advance_i   (run),
        .h_cnt_o     (h_cnt),
        .v_cnt_o     (v_cnt),
        .active_o    (cnt_active),
        .frame_end_o (frame_end)
    );

    assign act = run && cnt_active;

    // Read request has to reach the FIFO in the same cycle as the pixel slot;
    // reset suppresses it so nothing is consumed in the reset cycle.
    assign r_e = !RST && act && !empty;

    // Frame window covers the active lines and the blanking between them,
    // ending with the last active pixel of the last active line.
    assign frame_win = run
                    && (32'(v_cnt) < P_HEIGHT)
                    && !((32'(v_cnt) == (P_HEIGHT - 1)) && (32'(h_cnt) >= P_WIDTH));

    // Sequencer and registered output flags.
    always_ff @(posedge clk) begin
        if (RST) begin
            state_q       <= ST_IDLE;
            rd_q          <= 1'b0;
            line_valid_q  <= 1'b0;
            frame_valid_q <= 1'b0;
            underflow_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE:  if (en && !empty) state_q <= ST_PRIME;
                ST_PRIME: state_q <= ST_RUN;
                ST_RUN:   if (frame_end && !en) state_q <= ST_IDLE;
                default:  state_q <= ST_IDLE;
            endcase
            rd_q          <= r_e;
            line_valid_q  <= act;
            frame_valid_q <= frame_win;
            if (act && empty) begin
                underflow_q <= 1'b1;
            end
        end
    end

    // FIFO read data is itself a register output arriving one cycle after
    // r_e; the registered read flag selects it or blanks a starved slot.
    assign pixel_out   = rd_q ? pixel_in : '0;
    assign line_valid  = line_valid_q;
    assign frame_valid = frame_valid_q;
    assign underflow   = underflow_q;

endmodule : video_out_gen

// File: tb/tb_video_out_gen.sv
// ----------------------------------------------------------------------------
// tb_video_out_gen
// Directed bench for video_out_gen with an 8x4 picture, 4 blank cycles per
// line and 2 blank lines (12 cycles per line, 72 cycles per frame).
// ----------------------------------------------------------------------------
module tb_video_out_gen;

    logic       clk = 1'b0;
    logic       RST;
    logic       en;
    logic       empty;
    logic [7:0] pixel_in;
    logic       r_e;
    logic [7:0] pixel_out;
    logic       line_valid;
    logic       frame_valid;
    logic       underflow;

    int total = 0;
    int bad   = 0;

    // Pixel FIFO model: registered read data, one cycle after r_e.
    logic [7:0] mem [0:255];
    logic [7:0] wptr;
    logic [7:0] rptr;
    logic       fifo_clr;

    assign empty = (wptr == rptr);

    always @(posedge clk) begin
        if (fifo_clr) begin
            rptr <= 8'd0;
        end else if (r_e && !empty) begin
            pixel_in <= mem[rptr];
            rptr     <= rptr + 8'd1;
        end
    end

    always #5 clk = ~clk;

    video_out_gen #(
        .P_WIDTH  (8),
        .P_HEIGHT (4),
        .H_BLANK  (4),
        .V_BLANK  (2)
    ) dut (
        .clk         (clk),
        .RST         (RST),
        .en          (en),
        .empty       (empty),
        .pixel_in    (pixel_in),
        .r_e         (r_e),
        .pixel_out   (pixel_out),
        .line_valid  (line_valid),
        .frame_valid (frame_valid),
        .underflow   (underflow)
    );

    // Active slot for raster cycle c counted from the first RUN cycle.
    function automatic bit act(input int c);
        int f;
        f = c % 72;
        return ((f % 12) < 8) && ((f / 12) < 4);
    endfunction

    // Byte expected at raster cycle c when the FIFO holds 0,1,2,... in order.
    function automatic logic [7:0] pix(input int c);
        int f;
        f = c % 72;
        return 8'((c / 72) * 32 + (f / 12) * 8 + (f % 12));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        RST      = 1'b1;
        en       = 1'b0;
        fifo_clr = 1'b1;
        wptr     = 8'd0;
        @(negedge clk);
        @(negedge clk);
        RST      = 1'b0;
        fifo_clr = 1'b0;
    endtask

    task automatic load(input int n, input int base);
        for (int i = 0; i < n; i++) begin
            mem[wptr] = 8'(base + i);
            wptr      = wptr + 8'd1;
        end
    endtask

    // Raise en from IDLE and stop at the negedge of raster cycle 0.
    task automatic start();
        en = 1'b1;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        RST = 1'b1; en = 1'b0; fifo_clr = 1'b1; wptr = 8'd0;
        @(negedge clk);
        @(negedge clk);
        fifo_clr = 1'b0;
        load(4, 8'h10);
        en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (r_e !== 1'b0) begin bad++; $display("FAIL reset_r_e k=%0d got=%b want=0", k, r_e); end
            total++; if (pixel_out !== 8'h00) begin bad++; $display("FAIL reset_pixel k=%0d got=%h want=00", k, pixel_out); end
            total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL reset_lv k=%0d got=%b want=0", k, line_valid); end
            total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL reset_fv k=%0d got=%b want=0", k, frame_valid); end
            total++; if (underflow !== 1'b0) begin bad++; $display("FAIL reset_uf k=%0d got=%b want=0", k, underflow); end
        end
        total++; if (rptr !== 8'd0) begin bad++; $display("FAIL reset_no_read got=%0d want=0", rptr); end
        RST = 1'b0; en = 1'b0;
    endtask

    task automatic test_normal_frame();
        int lv_cnt = 0;
        int fv_cnt = 0;
        do_reset();
        load(32, 0);
        start();
        total++; if (r_e !== 1'b1) begin bad++; $display("FAIL nf_first_read got=%b want=1", r_e); end
        total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL nf_lv_after_prime got=%b want=0", line_valid); end
        for (int n = 1; n <= 72; n++) begin
            @(negedge clk);
            lv_cnt += int'(line_valid);
            fv_cnt += int'(frame_valid);
            total++; if (line_valid !== act(n - 1)) begin bad++; $display("FAIL nf_lv n=%0d got=%b want=%b", n, line_valid, act(n - 1)); end
            total++; if (pixel_out !== (act(n - 1) ? pix(n - 1) : 8'h00)) begin bad++; $display("FAIL nf_pixel n=%0d got=%h want=%h", n, pixel_out, act(n - 1) ? pix(n - 1) : 8'h00); end
            total++; if (frame_valid !== ((n - 1) < 44)) begin bad++; $display("FAIL nf_fv n=%0d got=%b want=%b", n, frame_valid, (n - 1) < 44); end
            total++; if (underflow !== 1'b0) begin bad++; $display("FAIL nf_uf n=%0d got=%b want=0", n, underflow); end
            total++; if (r_e !== (n < 72 && act(n))) begin bad++; $display("FAIL nf_r_e n=%0d got=%b want=%b", n, r_e, n < 72 && act(n)); end
        end
        total++; if (lv_cnt != 32) begin bad++; $display("FAIL nf_lv_count got=%0d want=32", lv_cnt); end
        total++; if (fv_cnt != 44) begin bad++; $display("FAIL nf_fv_count got=%0d want=44", fv_cnt); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        load(64, 0);
        start();
        for (int n = 1; n <= 84; n++) begin
            @(negedge clk);
            total++; if (line_valid !== act(n - 1)) begin bad++; $display("FAIL b2b_lv n=%0d got=%b want=%b", n, line_valid, act(n - 1)); end
            total++; if (pixel_out !== (act(n - 1) ? pix(n - 1) : 8'h00)) begin bad++; $display("FAIL b2b_pixel n=%0d got=%h want=%h", n, pixel_out, act(n - 1) ? pix(n - 1) : 8'h00); end
            total++; if (frame_valid !== (((n - 1) % 72) < 44)) begin bad++; $display("FAIL b2b_fv n=%0d got=%b want=%b", n, frame_valid, ((n - 1) % 72) < 44); end
        end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL b2b_uf got=%b want=0", underflow); end
    endtask

    task automatic test_underflow();
        do_reset();
        load(5, 8'hA0);
        start();
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            total++; if (line_valid !== ((n - 1) < 8)) begin bad++; $display("FAIL uf_lv n=%0d got=%b want=%b", n, line_valid, (n - 1) < 8); end
            total++; if (pixel_out !== (((n - 1) < 5) ? 8'(160 + n - 1) : 8'h00)) begin bad++; $display("FAIL uf_pixel n=%0d got=%h want=%h", n, pixel_out, ((n - 1) < 5) ? 8'(160 + n - 1) : 8'h00); end
            total++; if (underflow !== (n >= 6)) begin bad++; $display("FAIL uf_flag n=%0d got=%b want=%b", n, underflow, n >= 6); end
        end
        en = 1'b0;
        repeat (80) @(negedge clk);
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%b want=1", underflow); end
        total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL uf_idle_lv got=%b want=0", line_valid); end
    endtask

    task automatic test_en_drop();
        int lv_cnt = 0;
        int fv_cnt = 0;
        do_reset();
        load(64, 0);
        start();
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            lv_cnt += int'(line_valid);
            fv_cnt += int'(frame_valid);
            if (n <= 72) begin
                total++; if (line_valid !== act(n - 1)) begin bad++; $display("FAIL drop_lv n=%0d got=%b want=%b", n, line_valid, act(n - 1)); end
            end else begin
                total++; if (r_e !== 1'b0) begin bad++; $display("FAIL drop_idle_r_e n=%0d got=%b want=0", n, r_e); end
                total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL drop_idle_lv n=%0d got=%b want=0", n, line_valid); end
            end
            if (n == 12) en = 1'b0;
        end
        total++; if (lv_cnt != 32) begin bad++; $display("FAIL drop_lv_count got=%0d want=32", lv_cnt); end
        total++; if (fv_cnt != 44) begin bad++; $display("FAIL drop_fv_count got=%0d want=44", fv_cnt); end
        total++; if (rptr !== 8'd32) begin bad++; $display("FAIL drop_reads got=%0d want=32", rptr); end
        total++; if (empty !== 1'b0) begin bad++; $display("FAIL drop_fifo_left got=%b want=0", empty); end
    endtask

    task automatic test_rst_midline();
        do_reset();
        load(2, 8'h50);
        start();
        repeat (3) @(negedge clk);
        total++; if (underflow !== 1'b1) begin bad++; $display("FAIL rst_uf_before got=%b want=1", underflow); end
        load(8, 8'h60);
        RST = 1'b1;
        #1;
        total++; if (r_e !== 1'b0) begin bad++; $display("FAIL rst_cycle_r_e got=%b want=0", r_e); end
        @(negedge clk);
        total++; if (rptr !== 8'd2) begin bad++; $display("FAIL rst_no_read got=%0d want=2", rptr); end
        total++; if (pixel_out !== 8'h00) begin bad++; $display("FAIL rst_pixel got=%h want=00", pixel_out); end
        total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL rst_lv got=%b want=0", line_valid); end
        total++; if (frame_valid !== 1'b0) begin bad++; $display("FAIL rst_fv got=%b want=0", frame_valid); end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL rst_uf got=%b want=0", underflow); end
        RST = 1'b0;
        #1;
        total++; if (r_e !== 1'b0) begin bad++; $display("FAIL rst_idle_r_e got=%b want=0", r_e); end
        @(negedge clk);
        total++; if (r_e !== 1'b0) begin bad++; $display("FAIL rst_prime_r_e got=%b want=0", r_e); end
        total++; if (line_valid !== 1'b0) begin bad++; $display("FAIL rst_prime_lv got=%b want=0", line_valid); end
        @(negedge clk);
        total++; if (r_e !== 1'b1) begin bad++; $display("FAIL rst_run_r_e got=%b want=1", r_e); end
        @(negedge clk);
        total++; if (line_valid !== 1'b1) begin bad++; $display("FAIL rst_restart_lv got=%b want=1", line_valid); end
        total++; if (pixel_out !== 8'h60) begin bad++; $display("FAIL rst_restart_pixel got=%h want=60", pixel_out); end
        total++; if (underflow !== 1'b0) begin bad++; $display("FAIL rst_restart_uf got=%b want=0", underflow); end
    endtask

    initial begin
        RST      = 1'b1;
        en       = 1'b0;
        fifo_clr = 1'b1;
        wptr     = 8'd0;
        test_reset();
        test_normal_frame();
        test_back_to_back();
        test_underflow();
        test_en_drop();
        test_rst_midline();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_video_out_gen
